reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised general-purpose register file; generalises the single 32-bit enable/clear register to NUM_REGS entries.
- Two combinational read ports, one synchronous write port, optional write-to-read bypass and optional hardwired-zero R0.
- Per-register busy scoreboard: set when an instruction issues to a destination, cleared on writeback. Control logic uses it to stall on RAW hazards.
- Sits between the bus/datapath (BusMuxOut writeback) and operand latches.

Parameters:
- WIDTH, 32, data width of each register.
- NUM_REGS, 16, number of registers (power of two, >= 2).
- ADDR_W, $clog2(NUM_REGS), register address width.
- ZERO_R0, 1, 1 = R0 reads as 0, ignores writes, never goes busy.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-high reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- raddr_a  in  ADDR_W  read port A address.
- raddr_b  in  ADDR_W  read port B address.
- rdata_a  out  WIDTH  read port A data (combinational).
- rdata_b  out  WIDTH  read port B data (combinational).
- issue  in  1  mark issue_addr busy.
- issue_addr  in  ADDR_W  destination being issued.
- busy_a  out  1  busy bit of raddr_a (combinational).
- busy_b  out  1  busy bit of raddr_b (combinational).
- busy_vec  out  NUM_REGS  all busy bits; bit i is register i.

Behaviour:
- Reset:
  - clk is the only clock; clr is asynchronous and active-high.
  - clr asserted → all registers = 0 and all busy bits = 0 immediately, with no clock edge required.
  - While clr is high, rdata_a/b = 0, busy_a/b = 0 and busy_vec = 0.
  - clr has priority over everything, including mid-operation writes and issues.
- Write:
  - On posedge clk with we = 1, reg[waddr] <= wdata.
  - Write latency is 1 cycle into storage.
  - Without bypass, data is visible on a read port the cycle after the edge.
- Read:
  - rdata_x = reg[raddr_x], purely combinational.
  - Both ports may read the same address.
- Bypass (BYPASS = 1):
  - If we = 1 and raddr_x == waddr, rdata_x = wdata in that same cycle.
  - With ZERO_R0 = 1 and waddr == 0, no forwarding occurs.
- R0 (ZERO_R0 = 1):
  - Reads of address 0 return 0 and busy 0.
  - Writes to address 0 are dropped.
  - issue to address 0 is ignored.
  - busy_vec[0] is always 0.
- Scoreboard, per register, on posedge clk:
  - A write clears the busy bit of waddr when we = 1.
  - An issue sets the busy bit of issue_addr when issue = 1.
  - Same register in the same cycle: the set wins (the newer producer is pending); the data write still occurs.
  - Write and issue to different registers are independent.
  - Re-issuing an already-busy register keeps it busy; no counting.
  - A write to a non-busy register is legal and leaves it at 0.
  - busy_a/b reflect registered state only; a same-cycle write does not clear them combinationally.
- Address range: all addresses within 0..NUM_REGS-1 are valid; no out-of-range handling is needed.
- Output ports are combinational; the only state is storage plus busy bits.

Decomposition:
- Package reg_file_pkg:
  - Default WIDTH/NUM_REGS constants.
  - localparam REG_ZERO = 0.
  - Helper function for the ADDR_W computation.
- Sub-module reg_cell:
  - Parametrised WIDTH register with asynchronous clr and synchronous enable.
  - Instantiated NUM_REGS times through generate; the R0 instance is omitted or tied to 0 when ZERO_R0 = 1.
- Scoreboard logic stays inline: a simple per-bit set/clear.

Test Plan:
- Reset: pulse clr between clock edges with registers holding data → rdata_a/b = 0 and busy_vec = 0 before the next edge; after release, reading R5 returns 0.
- Write/read: we = 1, waddr = 3, wdata = 0xDEADBEEF, raddr_a = 3 → with BYPASS = 1, rdata_a = 0xDEADBEEF in the same cycle; with BYPASS = 0, old value (0) first, then 0xDEADBEEF after the edge; raddr_b = 3 agrees.
- R0: write 0x12345678 to addr 0 and issue addr 0 → rdata_a(addr 0) = 0, busy_vec[0] = 0, including the bypass cycle.
- Scoreboard: issue addr 7 → busy_vec = 0x0080 next cycle and busy_a = 1 when raddr_a = 7; write addr 7 with 0xA5 → busy clears next cycle and rdata = 0xA5.
- Collision: issue addr 4 and write addr 4 (0x55) in the same cycle while busy[4] = 1 → busy[4] stays 1, reg[4] = 0x55; separately, issue 2 plus write 9 → busy[2] = 1, busy[9] = 0.
- Parameter sweep: NUM_REGS = 4, WIDTH = 8, ZERO_R0 = 0 → write 0xFF to addr 0 reads back 0xFF and issue 0 sets busy_vec = 0x1; random write/issue streams are checked against a reference model for 1000 cycles.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// reg_file_pkg
//   Shared constants for the register file with busy scoreboard:
//   default geometry, the hardwired-zero register index and the
//   address-width helper.
package reg_file_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int REG_ZERO     = 0;

  // Address width for n registers; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_file_sb_reg_cell.sv
// reg_cell
//   One storage word with asynchronous clear and synchronous load enable.
//   Ports:
//     clk  rising-edge clock
//     clr  asynchronous active-high clear
//     en   load d on the next rising edge
//     d    data in
//     q    stored word
module reg_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
//   General-purpose register file with two combinational read ports, one
//   synchronous write port, optional write-to-read forwarding, optional
//   hardwired-zero R0 and a per-register busy scoreboard (set on issue,
//   cleared on writeback) used by control to stall on RAW hazards.
//   Ports:
//     clk, clr               clock, asynchronous active-high reset
//     we, waddr, wdata       writeback port
//     raddr_a/b, rdata_a/b   operand read ports (combinational)
//     issue, issue_addr      destination being issued (marks busy)
//     busy_a/b               registered busy bit of raddr_a/b
//     busy_vec               all busy bits, bit i = register i
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = addr_w(NUM_REGS),
  parameter int ZERO_R0  = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [ADDR_W-1:0]   raddr_a,
  input  logic [ADDR_W-1:0]   raddr_b,
  output logic [WIDTH-1:0]    rdata_a,
  output logic [WIDTH-1:0]    rdata_b,
  input  logic                issue,
  input  logic [ADDR_W-1:0]   issue_addr,
  output logic                busy_a,
  output logic                busy_b,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                w_fwd_ok;

  genvar i;
  generate
    for (i = 0; i < NUM_REGS; i++) begin : g_reg
      if (ZERO_R0 != 0 && i == REG_ZERO) begin : g_zero
        assign regs[i] = '0;
      end else begin : g_cell
        reg_cell #(.WIDTH(WIDTH)) u_cell (
          .clk (clk),
          .clr (clr),
          .en  (we && (waddr == ADDR_W'(i))),
          .d   (wdata),
          .q   (regs[i])
        );
      end
    end
  endgenerate

  // A write to the hardwired-zero register is dropped, so it must not
  // be forwarded either.
  assign w_fwd_ok = (BYPASS != 0) && we &&
                    !(ZERO_R0 != 0 && waddr == ADDR_W'(REG_ZERO));

  // Gating with clr keeps forwarded write data off the read ports while
  // the file is held in reset.
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    if (w_fwd_ok && waddr == raddr_a) rdata_a = wdata;
    if (w_fwd_ok && waddr == raddr_b) rdata_b = wdata;
    if (clr) begin
      rdata_a = '0;
      rdata_b = '0;
    end
  end

  // Issue is applied after writeback so a same-register collision leaves
  // the bit set: the newer producer is still outstanding.
  always_comb begin
    busy_nxt = busy;
    if (we)    busy_nxt[waddr]      = 1'b0;
    if (issue) busy_nxt[issue_addr] = 1'b1;
    if (ZERO_R0 != 0) busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign busy_a   = busy[raddr_a];
  assign busy_b   = busy[raddr_b];
  assign busy_vec = busy;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        clr = 1'b1;

  // default instance (BYPASS=1, ZERO_R0=1) and a no-bypass twin share inputs
  logic        we, issue;
  logic [3:0]  waddr, raddr_a, raddr_b, issue_addr;
  logic [31:0] wdata;
  logic [31:0] rd_a, rd_b, nb_rd_a, nb_rd_b;
  logic        busy_a, busy_b, nb_busy_a, nb_busy_b;
  logic [15:0] bv, nb_bv;

  // small instance: NUM_REGS=4, WIDTH=8, ZERO_R0=0
  logic        s_we, s_issue;
  logic [1:0]  s_waddr, s_ra, s_rb, s_ia;
  logic [7:0]  s_wdata, s_rd_a, s_rd_b;
  logic        s_busy_a, s_busy_b;
  logic [3:0]  s_bv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a), .rdata_b(rd_b),
    .issue(issue), .issue_addr(issue_addr),
    .busy_a(busy_a), .busy_b(busy_b), .busy_vec(bv)
  );

  reg_file_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(nb_rd_a), .rdata_b(nb_rd_b),
    .issue(issue), .issue_addr(issue_addr),
    .busy_a(nb_busy_a), .busy_b(nb_busy_b), .busy_vec(nb_bv)
  );

  reg_file_sb #(.NUM_REGS(4), .WIDTH(8), .ZERO_R0(0)) dut_s (
    .clk(clk), .clr(clr), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .raddr_a(s_ra), .raddr_b(s_rb), .rdata_a(s_rd_a), .rdata_b(s_rd_b),
    .issue(s_issue), .issue_addr(s_ia),
    .busy_a(s_busy_a), .busy_b(s_busy_b), .busy_vec(s_bv)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    issue = 1'b0; issue_addr = '0;
    s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_ra = '0; s_rb = '0;
    s_issue = 1'b0; s_ia = '0;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ra, rb;
    logic        iss;
    logic [3:0]  ia;
    logic [31:0] ea, eb;
    logic [15:0] ebv;
    logic        eba, ebb;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(logic w, logic [3:0] wa, logic [31:0] wd,
                              logic [3:0] ra, logic [3:0] rb, logic iss, logic [3:0] ia,
                              logic [31:0] ea, logic [31:0] eb, logic [15:0] ebv,
                              logic eba, logic ebb);
    vec_t v;
    v.we = w; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb; v.iss = iss; v.ia = ia;
    v.ea = ea; v.eb = eb; v.ebv = ebv; v.eba = eba; v.ebb = ebb;
    return v;
  endfunction

  // reference state for the random phase
  logic [31:0] m_mem [16];
  bit          m_busy[16];
  logic [7:0]  sm_mem [4];
  bit          sm_busy[4];

  initial begin
    logic [31:0] ea, eb, nea, neb;
    logic [15:0] ebv;
    logic [7:0]  sea, seb;
    logic [3:0]  sbv;

    // expected outputs observed mid-cycle, before that cycle's edge commits
    tbl[0]  = mk(1, 3, 32'hDEADBEEF, 3, 3, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 16'h0000, 0, 0);
    tbl[1]  = mk(0, 0, 32'h0,        3, 0, 0, 0, 32'hDEADBEEF, 32'h0,        16'h0000, 0, 0);
    tbl[2]  = mk(1, 0, 32'h12345678, 0, 0, 1, 0, 32'h0,        32'h0,        16'h0000, 0, 0);
    tbl[3]  = mk(0, 0, 32'h0,        0, 3, 1, 7, 32'h0,        32'hDEADBEEF, 16'h0000, 0, 0);
    tbl[4]  = mk(0, 0, 32'h0,        7, 7, 0, 0, 32'h0,        32'h0,        16'h0080, 1, 1);
    tbl[5]  = mk(1, 7, 32'hA5,       7, 3, 0, 0, 32'hA5,       32'hDEADBEEF, 16'h0080, 1, 0);
    tbl[6]  = mk(0, 0, 32'h0,        7, 0, 0, 0, 32'hA5,       32'h0,        16'h0000, 0, 0);
    tbl[7]  = mk(0, 0, 32'h0,        4, 0, 1, 4, 32'h0,        32'h0,        16'h0000, 0, 0);
    tbl[8]  = mk(1, 4, 32'h55,       4, 4, 1, 4, 32'h55,       32'h55,       16'h0010, 1, 1);
    tbl[9]  = mk(1, 9, 32'h99,       4, 9, 1, 2, 32'h55,       32'h99,       16'h0010, 1, 0);
    tbl[10] = mk(0, 0, 32'h0,        2, 9, 0, 0, 32'h0,        32'h99,       16'h0014, 1, 0);

    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rdata_a", rd_a, 32'h0);
    chk("reset_busy_vec", {16'h0, bv}, 32'h0);
    clr = 1'b0;

    // no-bypass twin: old value during the write cycle, new value after
    @(negedge clk);
    we = 1'b1; waddr = 4'd3; wdata = 32'hDEADBEEF; raddr_a = 4'd3; raddr_b = 4'd3;
    #1;
    chk("nobyp_same_cycle_a", nb_rd_a, 32'h0);
    chk("nobyp_same_cycle_b", nb_rd_b, 32'h0);
    chk("byp_same_cycle_a", rd_a, 32'hDEADBEEF);
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("nobyp_next_cycle_a", nb_rd_a, 32'hDEADBEEF);
    chk("nobyp_next_cycle_b", nb_rd_b, 32'hDEADBEEF);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
      raddr_a = tbl[i].ra; raddr_b = tbl[i].rb;
      issue = tbl[i].iss; issue_addr = tbl[i].ia;
      #1;
      chk($sformatf("tbl%0d_rdata_a", i), rd_a, tbl[i].ea);
      chk($sformatf("tbl%0d_rdata_b", i), rd_b, tbl[i].eb);
      chk($sformatf("tbl%0d_busy_vec", i), {16'h0, bv}, {16'h0, tbl[i].ebv});
      chk($sformatf("tbl%0d_busy_a", i), {31'h0, busy_a}, {31'h0, tbl[i].eba});
      chk($sformatf("tbl%0d_busy_b", i), {31'h0, busy_b}, {31'h0, tbl[i].ebb});
    end

    // asynchronous clear between edges, with a forwarding write pending
    @(negedge clk);
    we = 1'b1; waddr = 4'd3; wdata = 32'h1111; raddr_a = 4'd3; raddr_b = 4'd4;
    issue = 1'b1; issue_addr = 4'd5;
    #1;
    clr = 1'b1;
    #1;
    chk("clr_rdata_a", rd_a, 32'h0);
    chk("clr_rdata_b", rd_b, 32'h0);
    chk("clr_busy_vec", {16'h0, bv}, 32'h0);
    chk("clr_busy_b", {31'h0, busy_b}, 32'h0);
    chk("clr_nobyp_rdata_b", nb_rd_b, 32'h0);
    #1;
    clr = 1'b0;
    idle();
    @(negedge clk);
    raddr_a = 4'd5; raddr_b = 4'd3;
    #1;
    chk("post_clr_r5", rd_a, 32'h0);
    chk("post_clr_r3", rd_b, 32'h0);
    chk("post_clr_busy_vec", {16'h0, bv}, 32'h0);

    // small instance without hardwired zero
    @(negedge clk);
    s_we = 1'b1; s_waddr = 2'd0; s_wdata = 8'hFF; s_ra = 2'd0; s_rb = 2'd1;
    #1;
    chk("small_r0_bypass", {24'h0, s_rd_a}, 32'hFF);
    @(negedge clk);
    s_we = 1'b0; s_issue = 1'b1; s_ia = 2'd0;
    #1;
    chk("small_r0_readback", {24'h0, s_rd_a}, 32'hFF);
    chk("small_busy_before", {28'h0, s_bv}, 32'h0);
    @(negedge clk);
    s_issue = 1'b0;
    #1;
    chk("small_busy_vec", {28'h0, s_bv}, 32'h1);
    chk("small_busy_a", {31'h0, s_busy_a}, 32'h1);

    for (int k = 0; k < 16; k++) begin m_mem[k] = '0; m_busy[k] = 0; end
    for (int k = 0; k < 4; k++)  begin sm_mem[k] = '0; sm_busy[k] = 0; end
    sm_mem[0] = 8'hFF; sm_busy[0] = 1;

    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      we = ($urandom_range(1) == 1); waddr = 4'($urandom_range(15)); wdata = $urandom;
      raddr_a = 4'($urandom_range(15)); raddr_b = 4'($urandom_range(15));
      issue = ($urandom_range(2) == 0); issue_addr = 4'($urandom_range(15));
      if ($urandom_range(7) == 0) raddr_a = waddr;
      s_we = ($urandom_range(1) == 1); s_waddr = 2'($urandom_range(3)); s_wdata = 8'($urandom);
      s_ra = 2'($urandom_range(3)); s_rb = 2'($urandom_range(3));
      s_issue = ($urandom_range(1) == 1); s_ia = 2'($urandom_range(3));
      #1;

      // R0 reads zero; a live write to the same nonzero register forwards
      nea = (raddr_a == 0) ? 32'h0 : m_mem[raddr_a];
      neb = (raddr_b == 0) ? 32'h0 : m_mem[raddr_b];
      ea = (we && waddr != 0 && waddr == raddr_a) ? wdata : nea;
      eb = (we && waddr != 0 && waddr == raddr_b) ? wdata : neb;
      ebv = '0;
      for (int k = 0; k < 16; k++) ebv[k] = m_busy[k];
      chk("rnd_rdata_a", rd_a, ea);
      chk("rnd_rdata_b", rd_b, eb);
      chk("rnd_busy_vec", {16'h0, bv}, {16'h0, ebv});
      chk("rnd_busy_a", {31'h0, busy_a}, {31'h0, ebv[raddr_a]});
      chk("rnd_busy_b", {31'h0, busy_b}, {31'h0, ebv[raddr_b]});
      chk("rnd_nobyp_a", nb_rd_a, nea);
      chk("rnd_nobyp_b", nb_rd_b, neb);

      sea = (s_we && s_waddr == s_ra) ? s_wdata : sm_mem[s_ra];
      seb = (s_we && s_waddr == s_rb) ? s_wdata : sm_mem[s_rb];
      sbv = '0;
      for (int k = 0; k < 4; k++) sbv[k] = sm_busy[k];
      chk("rnd_small_rdata_a", {24'h0, s_rd_a}, {24'h0, sea});
      chk("rnd_small_rdata_b", {24'h0, s_rd_b}, {24'h0, seb});
      chk("rnd_small_busy_vec", {28'h0, s_bv}, {28'h0, sbv});
      chk("rnd_small_busy_a", {31'h0, s_busy_a}, {31'h0, sbv[s_ra]});
      chk("rnd_small_busy_b", {31'h0, s_busy_b}, {31'h0, sbv[s_rb]});

      // effect of the coming edge: writeback clears, issue sets (issue wins)
      if (we) begin
        if (waddr != 0) m_mem[waddr] = wdata;
        m_busy[waddr] = 0;
      end
      if (issue && issue_addr != 0) m_busy[issue_addr] = 1;
      if (s_we) begin
        sm_mem[s_waddr] = s_wdata;
        sm_busy[s_waddr] = 0;
      end
      if (s_issue) sm_busy[s_ia] = 1;
    end

    @(negedge clk);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
